// File: rtl/pipe_ctrl_fsm_pkg.sv
// Shared constants, state encoding and control bundle types
// for the pipeline main controller.
package pipe_ctrl_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JMP   = 6'h02;

    localparam logic [31:0] INSTR_NOP     = 32'h0000_0000;
    localparam logic [31:0] INSTR_SYSCALL = 32'h0000_000C;
    localparam logic [31:0] INSTR_HLT     = 32'hFFFF_FFFF;

    localparam int EX_W = 4;
    localparam int M_W  = 3;
    localparam int WB_W = 2;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_FINISH  = 2'd3
    } state_e;

    // ex = {RegDst,ALUOp[1:0],ALUSrc}, m = {Branch,MemRead,MemWrite},
    // wb = {RegWrite,MemtoReg}
    typedef struct packed {
        logic [EX_W-1:0] ex;
        logic [M_W-1:0]  m;
        logic [WB_W-1:0] wb;
    } ctrl_t;

    // special marks the all-zero-bundle R-type encodings (NOP, SYSCALL)
    function automatic ctrl_t decode_op(input logic [5:0] op,
                                        input logic special);
        ctrl_t c;
        c = '0;
        unique case (1'b1)
            (op == OP_RTYPE) && !special: c = '{4'b1100, 3'b000, 2'b10};
            (op == OP_LW):                c = '{4'b0001, 3'b010, 2'b11};
            (op == OP_SW):                c = '{4'b0001, 3'b001, 2'b00};
            (op == OP_BEQ):               c = '{4'b0010, 3'b100, 2'b00};
            default:                      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_fsm_if.sv
// ID-stage controller bus: instruction/hazard inputs and control outputs.
// Perf counters appear only when CTRL_PERF_CNT_EN is defined.
interface pipe_ctrl_fsm_if #(
    parameter int IW         = 32,
    parameter int NUM_STAGES = 5
);
    logic [IW-1:0]         instr;
    logic                  instr_valid;
    logic                  branch_not_taken;
    logic                  ex_mem_read;
    logic [4:0]            ex_rt;
    logic                  stall;
    logic [NUM_STAGES-1:0] flush;
    logic [3:0]            ex_ctrl;
    logic [2:0]            m_ctrl;
    logic [1:0]            wb_ctrl;
    logic                  busy;
    logic                  done;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]           cycle_cnt;
    logic [31:0]           stall_cnt;

    modport master (
        output instr, instr_valid, branch_not_taken, ex_mem_read, ex_rt,
        input  stall, flush, ex_ctrl, m_ctrl, wb_ctrl, busy, done,
        input  cycle_cnt, stall_cnt
    );
    modport slave (
        input  instr, instr_valid, branch_not_taken, ex_mem_read, ex_rt,
        output stall, flush, ex_ctrl, m_ctrl, wb_ctrl, busy, done,
        output cycle_cnt, stall_cnt
    );
`else
    modport master (
        output instr, instr_valid, branch_not_taken, ex_mem_read, ex_rt,
        input  stall, flush, ex_ctrl, m_ctrl, wb_ctrl, busy, done
    );
    modport slave (
        input  instr, instr_valid, branch_not_taken, ex_mem_read, ex_rt,
        output stall, flush, ex_ctrl, m_ctrl, wb_ctrl, busy, done
    );
`endif
endinterface

// File: rtl/pipe_ctrl_fsm_hazard_unit.sv
// Combinational load-use stall and misprediction flush generation.
// A misprediction overrides a load-use stall in the same cycle.
module pipe_hazard_unit #(
    parameter int NUM_STAGES  = 5,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                  exec,
    input  logic                  instr_valid,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rt,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic                  branch_not_taken,
    output logic                  stall,
    output logic [NUM_STAGES-1:0] flush
);

    logic load_use;
    logic mispred;

    // stall/flush decision; flush covers only the front FLUSH_DEPTH stages
    always_comb begin
        load_use = instr_valid && ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == rs) || (ex_rt == rt));
        mispred  = exec && branch_not_taken;
        stall    = exec && load_use && !mispred;
        flush    = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            flush[i] = mispred && (i < FLUSH_DEPTH);
        end
    end

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Main pipeline controller: decode to registered EX/M/WB bundles,
// hazard bubbles, flush, HLT drain. Option: CTRL_PERF_CNT_EN.
module pipe_ctrl_fsm #(
    parameter int IW           = 32,
    parameter int NUM_STAGES   = 5,
    parameter int FLUSH_DEPTH  = 1,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_fsm_if.slave  bus
);
    import pipe_ctrl_fsm_pkg::*;

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic                  done_q, done_d;
    logic                  stall;
    logic [NUM_STAGES-1:0] flush;
    logic                  exec;
    logic                  special;
    logic                  is_hlt;

    assign exec    = (state_q == ST_EXECUTE);
    assign special = (bus.instr == IW'(INSTR_NOP)) ||
                     (bus.instr == IW'(INSTR_SYSCALL));
    assign is_hlt  = (bus.instr == IW'(INSTR_HLT));

    pipe_hazard_unit #(
        .NUM_STAGES  (NUM_STAGES),
        .FLUSH_DEPTH (FLUSH_DEPTH)
    ) u_hazard (
        .exec             (exec),
        .instr_valid      (bus.instr_valid),
        .ex_mem_read      (bus.ex_mem_read),
        .ex_rt            (bus.ex_rt),
        .rs               (bus.instr[25:21]),
        .rt               (bus.instr[20:16]),
        .branch_not_taken (bus.branch_not_taken),
        .stall            (stall),
        .flush            (flush)
    );

    // next state, drain count and the bundle to register (zero = bubble)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = '0;
        unique case (state_q)
            ST_RESET: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (bus.instr_valid && !stall && (flush == '0))
                    ctrl_d = decode_op(bus.instr[IW-1:IW-6], special);
                if (bus.instr_valid && is_hlt && !stall) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CW'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_FINISH;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_FINISH: state_d = ST_FINISH;
            default:   state_d = ST_RESET;
        endcase
        done_d = (state_d == ST_FINISH);
    end

    // controller state and registered bundles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
        end
    end

    assign bus.stall   = stall;
    assign bus.flush   = flush;
    assign bus.ex_ctrl = ctrl_q.ex;
    assign bus.m_ctrl  = ctrl_q.m;
    assign bus.wb_ctrl = ctrl_q.wb;
    assign bus.busy    = (state_q == ST_EXECUTE) || (state_q == ST_DRAIN);
    assign bus.done    = done_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] stl_q, stl_d;

    // counters advance only while busy, so they freeze in FINISH
    always_comb begin
        cyc_d = cyc_q;
        stl_d = stl_q;
        if (bus.busy) cyc_d = cyc_q + 32'd1;
        if (stall)    stl_d = stl_q + 32'd1;
    end

    // perf counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            stl_q <= stl_d;
        end
    end

    assign bus.cycle_cnt = cyc_q;
    assign bus.stall_cnt = stl_q;
`endif

endmodule

// File: doc/pipe_ctrl_fsm.md
Name: pipe_ctrl_fsm

Overview:
- Parametrised main controller for the 5-stage MIPS-subset pipeline; successor to the single-issue fixed controller.
- Decodes the ID-stage instruction into registered EX/M/WB control bundles, which drive the ID/EX register.
- Detects load-use hazards and inserts one bubble per hazard cycle; generates a per-stage flush vector on branch misprediction.
- On HLT, drains the pipeline for a programmable number of cycles before asserting done.

Parameters:
- IW, 32, instruction width; opcode field is always bits [IW-1:IW-6]
- NUM_STAGES, 5, pipeline depth; width of flush vector
- FLUSH_DEPTH, 1, number of front stages flushed on branch_not_taken (1..NUM_STAGES-1)
- DRAIN_CYCLES, 4, cycles spent in DRAIN after HLT accepted (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- instr  in  IW  ID-stage instruction
- instr_valid  in  1  instr is meaningful this cycle
- branch_not_taken  in  1  misprediction resolved this cycle
- ex_mem_read  in  1  EX-stage instruction is a load
- ex_rt  in  5  EX-stage load destination register
- stall  out  1  hold PC and IF/ID (combinational)
- flush  out  NUM_STAGES  per-stage flush; bit 0 = IF (combinational)
- ex_ctrl  out  4  registered EX bundle {RegDst,ALUOp[1:0],ALUSrc}
- m_ctrl  out  3  registered M bundle {Branch,MemRead,MemWrite}
- wb_ctrl  out  2  registered WB bundle {RegWrite,MemtoReg}
- busy  out  1  state is EXECUTE or DRAIN
- done  out  1  registered; high only in FINISH

Behaviour:
- Reset (async): state=RESET; ex_ctrl/m_ctrl/wb_ctrl=0, done=0, drain counter=0. stall, flush and busy evaluate to 0 in RESET.
- States and transitions:
  - RESET -> EXECUTE unconditionally after one cycle.
  - EXECUTE -> DRAIN when instr_valid and instr==HLT and stall==0; drain counter loads DRAIN_CYCLES-1.
  - DRAIN decrements the counter each cycle; at 0 -> FINISH.
  - FINISH is sticky until rst.
- Decode (EXECUTE, instr_valid, no stall, no flush); bundles update at the next edge (latency 1):
  - R-type excluding NOP/SYSCALL: EX=1100, M=000, WB=10
  - LW: EX=0001, M=010, WB=11
  - SW: EX=0001, M=001, WB=00
  - BEQ: EX=0010, M=100, WB=00
  - JMP, NOP, SYSCALL, HLT, unknown opcode, instr_valid=0: all zero.
- Load-use hazard: stall = EXECUTE & instr_valid & ex_mem_read & ex_rt!=0 & (ex_rt==instr[25:21] | ex_rt==instr[20:16]). While stall is high, bundles register zero (bubble). The instruction is re-presented and decoded once stall drops.
- Branch: in EXECUTE, branch_not_taken sets flush[FLUSH_DEPTH-1:0]=1; higher flush bits are always 0. Bundles register zero that cycle.
- Branch and hazard in the same cycle: flush wins, stall forced 0.
- HLT presented during stall is not accepted; it is accepted on the first non-stall cycle.
- DRAIN and FINISH: bundles 0, stall 0, flush 0; instr ignored.
- rst mid-DRAIN: returns to RESET immediately, counter cleared.

Optional Feature:
- CTRL_PERF_CNT_EN: adds outputs cycle_cnt[31:0] (increments every cycle in EXECUTE/DRAIN) and stall_cnt[31:0] (increments on each stall cycle). Both are async-reset to 0, wrap at 2^32, and freeze in FINISH.
- Without the macro: ports and logic absent; the core behaviour is identical.

Decomposition:
- Shared package/defines hold:
  - opcode constants: RTYPE=6'h00, LW=6'h23, SW=6'h2B, BEQ=6'h04, JMP=6'h02
  - NOP=32'h0000_0000, SYSCALL=32'h0000_000C, HLT=32'hFFFF_FFFF
  - state encoding: RESET=0, EXECUTE=1, DRAIN=2, FINISH=3
  - bundle widths
- One natural sub-module: pipe_hazard_unit (combinational stall/flush generation), instantiated once.

Test Plan:
- Reset then LW (opcode 0x23), valid -> after 1 edge EX=0001, M=010, WB=11; busy=1.
- ex_mem_read=1, ex_rt=5, instr=ADD with rs=5 -> stall=1, next bundles all 0; drop ex_mem_read -> ADD decodes to EX=1100, WB=10.
- ex_rt=0 with matching rs=0 -> stall stays 0.
- FLUSH_DEPTH=2, branch_not_taken=1 together with a hazard -> flush=5'b00011, stall=0, bundles 0.
- HLT with DRAIN_CYCLES=4 -> exactly 4 DRAIN cycles, then done=1 sticky; rst asserted mid-DRAIN -> done=0, state RESET, all outputs 0.
- With CTRL_PERF_CNT_EN: program of 10 EXECUTE cycles with 2 stalls, then HLT with DRAIN_CYCLES=4 -> stall_cnt=2, cycle_cnt=14 frozen in FINISH.
